msdf_mult_arbiter: RTL and testbench

//  Round-robin scheduler sharing one OnTheFly_Multiply_Interface between NUM_REQ PE requesters.

---
 rtl/msdf_mult_arbiter_if.sv | 42 ++++
 rtl/msdf_mult_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_msdf_mult_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msdf_mult_arbiter_if.sv
// ----------------------------------------------------------------------------
// msdf_mult_arbiter_if
//   Digit-serial bus between the requester arbiter and a shared on-the-fly
//   (MSD-first) multiplier.
//
//   Write channel (arbiter -> multiplier):
//     wen      write enable
//     wdata_x  X operand digit
//     wdata_y  Y operand digit
//     wvalid   digit valid
//     wlast    last digit of the job
//     wready   multiplier ready (multiplier -> arbiter)
//   Read channel (multiplier -> arbiter, no backpressure):
//     rdata    result digit
//     rvalid   result digit valid
//     rlast    last result digit of the job
//
//   master: arbiter side.  slave: multiplier side.
// ----------------------------------------------------------------------------
interface msdf_mult_arbiter_if #(
    parameter int DATA_WIDTH = 2
);
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata_x;
    logic [DATA_WIDTH-1:0] wdata_y;
    logic                  wvalid;
    logic                  wlast;
    logic                  wready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rlast;

    modport master (
        output wen, wdata_x, wdata_y, wvalid, wlast,
        input  wready, rdata, rvalid, rlast
    );

    modport slave (
        input  wen, wdata_x, wdata_y, wvalid, wlast,
        output wready, rdata, rvalid, rlast
    );
endinterface

// File: rtl/msdf_mult_arbiter.sv
// ----------------------------------------------------------------------------
// msdf_mult_arbiter
//   Round-robin scheduler that shares one on-the-fly multiplier between
//   NUM_REQ processing elements. One job runs at a time: the granted
//   requester's X/Y digit vectors are latched, streamed MSD-first on the
//   write channel, and result digits coming back on the read channel are
//   forwarded one cycle later tagged with the owner's id.
//
//   Ports:
//     i_clk, i_rstn   clock, asynchronous active-low reset
//     i_req           per-requester job request (level)
//     i_req_x/y       packed operands; requester r at slice r,
//                     digit j at [j*DATA_WIDTH +: DATA_WIDTH] inside a slice
//     i_prec          digits per job, sampled at grant
//                     (0 or > ACCURATE_MAX selects ACCURATE_MAX)
//     o_gnt           one-hot single-cycle grant pulse
//     o_busy          job in flight
//     mbus            multiplier bus (master side)
//     o_res_*         result digit / valid / last / owner id
// ----------------------------------------------------------------------------
module msdf_mult_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int DATA_WIDTH   = 2,
    parameter int ACCURATE_MAX = 16,
    parameter int PREC_W       = 5
) (
    input  logic                                       i_clk,
    input  logic                                       i_rstn,
    input  logic [NUM_REQ-1:0]                         i_req,
    input  logic [NUM_REQ*ACCURATE_MAX*DATA_WIDTH-1:0] i_req_x,
    input  logic [NUM_REQ*ACCURATE_MAX*DATA_WIDTH-1:0] i_req_y,
    input  logic [PREC_W-1:0]                          i_prec,
    output logic [NUM_REQ-1:0]                         o_gnt,
    output logic                                       o_busy,
    msdf_mult_arbiter_if.master                        mbus,
    output logic [DATA_WIDTH-1:0]                      o_res_data,
    output logic                                       o_res_valid,
    output logic                                       o_res_last,
    output logic [ID_W-1:0]                            o_res_id
);

    localparam int                SLICE_W  = ACCURATE_MAX * DATA_WIDTH;
    localparam int                SEL_W    = (ACCURATE_MAX > 1) ? $clog2(ACCURATE_MAX) : 1;
    localparam logic [PREC_W-1:0] PREC_MAX = PREC_W'(ACCURATE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DRAIN
    } state_e;

    typedef logic [ACCURATE_MAX-1:0][DATA_WIDTH-1:0] digits_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q,     state_d;
    logic [ID_W-1:0]        ptr_q,       ptr_d;
    logic [ID_W-1:0]        id_q,        id_d;
    logic [PREC_W-1:0]      prec_q,      prec_d;
    logic [PREC_W-1:0]      k_q,         k_d;
    digits_t                x_q,         x_d;
    digits_t                y_q,         y_d;
    logic                   wr_done_q,   wr_done_d;
    logic                   rd_done_q,   rd_done_d;
    logic [NUM_REQ-1:0]     gnt_q,       gnt_d;
    logic                   busy_q,      busy_d;
    logic                   wvalid_q,    wvalid_d;
    logic                   wlast_q,     wlast_d;
    logic [DATA_WIDTH-1:0]  wdata_x_q,   wdata_x_d;
    logic [DATA_WIDTH-1:0]  wdata_y_q,   wdata_y_d;
    logic [DATA_WIDTH-1:0]  res_data_q,  res_data_d;
    logic                   res_valid_q, res_valid_d;
    logic                   res_last_q,  res_last_d;
    logic [ID_W-1:0]        res_id_q,    res_id_d;

    logic                   pick_found;
    logic [ID_W-1:0]        pick_id;
    logic [ID_W-1:0]        cand;
    logic [PREC_W-1:0]      k_inc;

    // Beat k carries digit ACCURATE_MAX-1-k (most significant first).
    function automatic logic [SEL_W-1:0] digit_sel(input logic [PREC_W-1:0] k);
        return SEL_W'(ACCURATE_MAX - 1) - SEL_W'(k);
    endfunction

    assign k_inc = k_q + PREC_W'(1);

    // ------------------------------------------------------------------
    // Round-robin pick: first set request starting at ptr_q, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!pick_found && i_req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        prec_d      = prec_q;
        k_d         = k_q;
        x_d         = x_q;
        y_d         = y_q;
        wr_done_d   = wr_done_q;
        rd_done_d   = rd_done_q;
        wvalid_d    = wvalid_q;
        wlast_d     = wlast_q;
        wdata_x_d   = wdata_x_q;
        wdata_y_d   = wdata_y_q;
        gnt_d       = '0;
        res_data_d  = '0;
        res_valid_d = 1'b0;
        res_last_d  = 1'b0;
        res_id_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d[pick_id] = 1'b1;
                    for (int unsigned r = 0; r < NUM_REQ; r++) begin
                        if (pick_id == ID_W'(r)) begin
                            x_d = i_req_x[r*SLICE_W +: SLICE_W];
                            y_d = i_req_y[r*SLICE_W +: SLICE_W];
                        end
                    end
                    prec_d    = (i_prec == '0 || i_prec > PREC_MAX) ? PREC_MAX : i_prec;
                    id_d      = pick_id;
                    ptr_d     = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);
                    k_d       = '0;
                    wr_done_d = 1'b0;
                    rd_done_d = 1'b0;
                    state_d   = ST_SEND;
                end
            end

            ST_SEND, ST_DRAIN: begin
                // Result digits are forwarded whenever a job owns the bus,
                // even before the write stream has finished (online delay).
                if (mbus.rvalid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = mbus.rdata;
                    res_last_d  = mbus.rlast;
                    res_id_d    = id_q;
                    if (mbus.rlast) begin
                        rd_done_d = 1'b1;
                    end
                end

                if (state_q == ST_SEND && !wr_done_q) begin
                    if (!wvalid_q) begin
                        // Grant cycle: present beat 0 on the following cycle.
                        wvalid_d  = 1'b1;
                        wdata_x_d = x_q[digit_sel(k_q)];
                        wdata_y_d = y_q[digit_sel(k_q)];
                        wlast_d   = (k_q == prec_q - PREC_W'(1));
                    end else if (mbus.wready) begin
                        if (wlast_q) begin
                            wvalid_d  = 1'b0;
                            wlast_d   = 1'b0;
                            wdata_x_d = '0;
                            wdata_y_d = '0;
                            wr_done_d = 1'b1;
                        end else begin
                            k_d       = k_inc;
                            wdata_x_d = x_q[digit_sel(k_inc)];
                            wdata_y_d = y_q[digit_sel(k_inc)];
                            wlast_d   = (k_inc == prec_q - PREC_W'(1));
                        end
                    end
                end

                // Leave as soon as both directions are complete; the flags
                // are evaluated on their next values so an rlast that lands
                // with the final write handshake skips DRAIN.
                if (wr_done_d && rd_done_d) begin
                    state_d   = ST_IDLE;
                    wr_done_d = 1'b0;
                    rd_done_d = 1'b0;
                end else if (wr_done_d) begin
                    state_d = ST_DRAIN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            prec_q      <= '0;
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            wdata_x_q   <= '0;
            wdata_y_q   <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            prec_q      <= prec_d;
            k_q         <= k_d;
            x_q         <= x_d;
            y_q         <= y_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            wdata_x_q   <= wdata_x_d;
            wdata_y_q   <= wdata_y_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            res_id_q    <= res_id_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_gnt        = gnt_q;
    assign o_busy       = busy_q;
    assign mbus.wen     = wvalid_q;
    assign mbus.wvalid  = wvalid_q;
    assign mbus.wlast   = wlast_q;
    assign mbus.wdata_x = wdata_x_q;
    assign mbus.wdata_y = wdata_y_q;
    assign o_res_data   = res_data_q;
    assign o_res_valid  = res_valid_q;
    assign o_res_last   = res_last_q;
    assign o_res_id     = res_id_q;

endmodule

// File: tb/tb_msdf_mult_arbiter.sv
// ----------------------------------------------------------------------------
// tb_msdf_mult_arbiter
//   Directed bench for msdf_mult_arbiter. Expected write beats are queued at
//   grant from the operands the bench drove; expected result digits are
//   queued when the bench drives the read channel and must appear exactly
//   one cycle later with the owner's id.
// ----------------------------------------------------------------------------
module tb_msdf_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DW      = 2;
    localparam int AM      = 16;
    localparam int PREC_W  = 5;
    localparam int SLICE   = AM * DW;

    logic                       clk = 1'b0;
    logic                       rstn;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*SLICE-1:0]   req_x;
    logic [NUM_REQ*SLICE-1:0]   req_y;
    logic [PREC_W-1:0]          prec;
    logic [NUM_REQ-1:0]         gnt;
    logic                       busy;
    logic [DW-1:0]              res_data;
    logic                       res_valid;
    logic                       res_last;
    logic [ID_W-1:0]            res_id;

    always #5 clk = ~clk;

    msdf_mult_arbiter_if #(.DATA_WIDTH(DW)) mbus ();

    msdf_mult_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ID_W         (ID_W),
        .DATA_WIDTH   (DW),
        .ACCURATE_MAX (AM),
        .PREC_W       (PREC_W)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_req       (req),
        .i_req_x     (req_x),
        .i_req_y     (req_y),
        .i_prec      (prec),
        .o_gnt       (gnt),
        .o_busy      (busy),
        .mbus        (mbus),
        .o_res_data  (res_data),
        .o_res_valid (res_valid),
        .o_res_last  (res_last),
        .o_res_id    (res_id)
    );

    typedef struct packed {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0]   d;
        logic            last;
        logic [ID_W-1:0] id;
        int              stamp;
    } res_t;

    beat_t beat_q[$];
    res_t  res_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int step_no  = 0;
    int cur_id   = 0;
    int grant_step;
    int beats_done;
    int first_hs;
    int wl_step;
    bit rlast_sent;
    bit rl_by_wl;
    bit ignore_rv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_prec(input int p);
        return (p == 0 || p > AM) ? AM : p;
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < NUM_REQ*SLICE/32; i++) begin
            req_x[i*32 +: 32] = $urandom;
            req_y[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},       gnt,          0);
        chk({tag, "_busy"},      busy,         0);
        chk({tag, "_wen"},       mbus.wen,     0);
        chk({tag, "_wvalid"},    mbus.wvalid,  0);
        chk({tag, "_wlast"},     mbus.wlast,   0);
        chk({tag, "_wdata_x"},   mbus.wdata_x, 0);
        chk({tag, "_wdata_y"},   mbus.wdata_y, 0);
        chk({tag, "_res_valid"}, res_valid,    0);
        chk({tag, "_res_data"},  res_data,     0);
        chk({tag, "_res_last"},  res_last,     0);
        chk({tag, "_res_id"},    res_id,       0);
    endtask

    // One clock: check outputs at the falling edge, then drive the inputs
    // that the next rising edge will sample.
    task automatic step(input logic wr, input logic rv, input logic [DW-1:0] rd, input logic rl);
        logic  exp_v;
        res_t  e;
        beat_t b;
        @(negedge clk);
        step_no++;
        exp_v = (res_q.size() > 0) && (res_q[0].stamp == step_no - 1);
        chk("res_valid", res_valid, exp_v);
        if (exp_v) begin
            e = res_q.pop_front();
            if (res_valid === 1'b1) begin
                chk("res_data", res_data, e.d);
                chk("res_last", res_last, e.last);
                chk("res_id",   res_id,   e.id);
            end
        end
        mbus.wready = wr;
        mbus.rvalid = rv;
        mbus.rdata  = rd;
        mbus.rlast  = rl;
        if (rv && !ignore_rv) begin
            res_q.push_back('{d: rd, last: rl, id: ID_W'(cur_id), stamp: step_no});
            if (rl) rlast_sent = 1'b1;
        end
        if (mbus.wvalid === 1'b1 && wr) begin
            if (beat_q.size() == 0) begin
                chk("beat_extra", mbus.wvalid, 0);
            end else begin
                b = beat_q.pop_front();
                chk("wen",     mbus.wen,     1);
                chk("wdata_x", mbus.wdata_x, b.x);
                chk("wdata_y", mbus.wdata_y, b.y);
                chk("wlast",   mbus.wlast,   b.last);
                beats_done++;
                if (first_hs < 0) first_hs = step_no;
                if (mbus.wlast === 1'b1) begin
                    wl_step  = step_no;
                    rl_by_wl = rlast_sent;
                end
            end
        end
    endtask

    task automatic wait_grant(input int exp_id, input int pe);
        int    n;
        int    j;
        beat_t b;
        n = 0;
        do begin
            step(1'b1, 1'b0, '0, 1'b0);
            n++;
        end while (gnt === '0 && n < 50);
        chk("gnt",        gnt,  4'b0001 << exp_id);
        chk("gnt_lat",    n,    1);
        chk("busy_at_gnt", busy, 1);
        cur_id     = exp_id;
        grant_step = step_no;
        for (int k = 0; k < pe; k++) begin
            j      = AM - 1 - k;
            b.x    = req_x[(exp_id*AM + j)*DW +: DW];
            b.y    = req_y[(exp_id*AM + j)*DW +: DW];
            b.last = (k == pe - 1);
            beat_q.push_back(b);
        end
    endtask

    task automatic run_job(input logic [NUM_REQ-1:0] req_v, input bit hold, input int prec_v,
                           input int exp_id, input bit bp, input int nres, input int rst_at);
        int   pe;
        int   r_sent;
        int   h1;
        int   h2;
        logic wr;
        logic rv;
        logic rl;
        pe         = eff_prec(prec_v);
        beats_done = 0;
        first_hs   = -1;
        wl_step    = -1;
        rlast_sent = 1'b0;
        rl_by_wl   = 1'b0;
        r_sent     = 0;
        h1         = 0;
        h2         = 0;
        randomize_ops();
        req  = req_v;
        prec = PREC_W'(prec_v);
        wait_grant(exp_id, pe);
        // Operands and precision must have been captured at grant.
        if (!hold) req = '0;
        randomize_ops();
        prec = PREC_W'($urandom);
        for (int c = 1; c < 400; c++) begin
            if (rst_at >= 0 && beats_done == rst_at) begin
                #2 rstn = 1'b0;
                #1 chk_all_zero("rst_mid");
                beat_q.delete();
                res_q.delete();
                mbus.rvalid = 1'b0;
                mbus.rlast  = 1'b0;
                req         = '0;
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            wr = 1'b1;
            if (bp && beats_done == 1 && h1 < 2) begin wr = 1'b0; h1++; end
            if (bp && beats_done == 2 && h2 < 2) begin wr = 1'b0; h2++; end
            rv = (c >= 2) && (r_sent < nres);
            rl = rv && (r_sent == nres - 1);
            step(wr, rv, 2'($urandom), rl);
            if (rv) r_sent++;
            if (c == 1) chk("gnt_pulse", gnt, 0);
            if (wl_step >= 0 && step_no == wl_step + 1) chk("busy_after_wlast", busy, !rl_by_wl);
            if (beats_done == pe && r_sent == nres && wl_step >= 0 &&
                step_no > wl_step && busy === 1'b0) break;
        end
        chk("beats",      beats_done,            pe);
        chk("first_beat", first_hs - grant_step, 1);
        chk("last_beat",  wl_step - grant_step,  pe + (bp ? 4 : 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        req         = '0;
        prec        = '0;
        mbus.wready = 1'b0;
        mbus.rvalid = 1'b0;
        mbus.rdata  = '0;
        mbus.rlast  = 1'b0;
        randomize_ops();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("idle_no_gnt", gnt, 0);

        // Single job, 4 digits: 15,14,13,12; result finishes after writes (DRAIN).
        run_job(4'b0001, 1'b0, 4, 0, 1'b0, 4, -1);

        // Read channel activity with no job in flight is ignored.
        ignore_rv = 1'b1;
        step(1'b1, 1'b1, 2'b11, 1'b1);
        ignore_rv = 1'b0;
        step(1'b1, 1'b0, '0, 1'b0);
        chk("idle_rvalid_busy", busy, 0);

        // Backpressure on beats 1 and 2.
        run_job(4'b0010, 1'b0, 6, 1, 1'b1, 6, -1);

        // rlast arrives during beat 2 of 4: straight back to IDLE.
        run_job(4'b0100, 1'b0, 4, 2, 1'b0, 2, -1);

        // prec=0 selects 16 digits; 16 results routed to id 2 (ptr at 3 wraps).
        run_job(4'b0100, 1'b0, 0, 2, 1'b0, 16, -1);

        // Reset while beat 3 is on the bus (ptr was 3, so id 1 wins).
        run_job(4'b0010, 1'b0, 8, 1, 1'b0, 1, 3);

        // All requesting after reset: order starts at 0 and wraps after 3.
        run_job(4'b1111, 1'b1, 1,  0, 1'b0, 1, -1);
        run_job(4'b1111, 1'b1, 2,  1, 1'b0, 2, -1);
        run_job(4'b1111, 1'b1, 17, 2, 1'b0, 3, -1);
        run_job(4'b1111, 1'b1, 3,  3, 1'b0, 3, -1);
        run_job(4'b1111, 1'b1, 4,  0, 1'b0, 4, -1);
        req = '0;

        step(1'b1, 1'b0, '0, 1'b0);
        chk("end_no_gnt", gnt, 0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("end_busy", busy, 0);
        chk("end_wvalid", mbus.wvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
